uart_led_cmd: RTL

Line-oriented command parser that sits directly downstream of the `UART` receiver and upstream of its transmitter. It consumes received bytes (`o_Received`/`o_Data`), decodes ASCII commands terminated by LF, drives the LED register, and sends short ASCII replies back through the UART's `i_Start`/`i_Data`/`busy` interface.

---
 rtl/uart_led_cmd_pkg.sv | 39 +++
 rtl/uart_tx_sequencer.sv | 95 +++++++++
 rtl/uart_led_cmd.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/uart_led_cmd_pkg.sv
// Shared constants, state encodings and ASCII/hex helpers for the UART LED command parser.
package uart_led_cmd_pkg;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_L  = 8'h4C;
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_K  = 8'h4B;
    localparam logic [7:0] ASCII_QM = 8'h3F;

    localparam int BUSY_TIMEOUT_DEF = 4;

    typedef enum logic [2:0] {
        P_IDLE, P_GOT_L, P_HEX1, P_HEX2, P_GOT_R, P_BAD
    } parse_state_e;

    typedef enum logic [1:0] {
        R_IDLE, R_SEND, R_WAIT_HI, R_WAIT_LO
    } reply_state_e;

    function automatic logic is_hex(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) ||
               (c >= 8'h41 && c <= 8'h46) ||
               (c >= 8'h61 && c <= 8'h66);
    endfunction

    function automatic logic [3:0] hex_to_nibble(input logic [7:0] c);
        logic [7:0] v;
        if (c <= 8'h39)      v = c - 8'h30;
        else if (c >= 8'h61) v = c - 8'h57;
        else                 v = c - 8'h37;
        return v[3:0];
    endfunction

    function automatic logic [7:0] nibble_to_hex(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Holds up to 3 reply bytes and hands them one at a time to the UART transmitter,
// pacing on the busy handshake with a timeout in case busy never rises.
module uart_tx_sequencer
    import uart_led_cmd_pkg::*;
#(
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            load_i,
    input  logic [2:0][7:0] bytes_i,
    input  logic [1:0]      len_i,
    input  logic            busy_i,
    output logic            start_o,
    output logic [7:0]      tx_data_o,
    output logic            active_o
);

    localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);

    reply_state_e    state_q, state_d;
    logic [2:0][7:0] buf_q, buf_d;
    logic [1:0]      len_q, len_d;
    logic [1:0]      idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]      tx_q, tx_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= R_IDLE;
            buf_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        len_d   = len_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        tx_d    = tx_q;
        start_o = 1'b0;
        case (state_q)
            R_IDLE: begin
                if (load_i && len_i != 2'd0) begin
                    buf_d   = bytes_i;
                    len_d   = len_i;
                    idx_d   = 2'd0;
                    tx_d    = bytes_i[0];
                    state_d = R_SEND;
                end
            end
            // Stall here while the transmitter is still busy from an earlier byte.
            R_SEND: begin
                if (!busy_i) begin
                    start_o = 1'b1;
                    cnt_d   = '0;
                    state_d = R_WAIT_HI;
                end
            end
            R_WAIT_HI: begin
                if (busy_i || cnt_q == CNT_LAST) state_d = R_WAIT_LO;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            R_WAIT_LO: begin
                if (!busy_i) begin
                    if (idx_q == len_q - 2'd1) begin
                        state_d = R_IDLE;
                    end else begin
                        idx_d   = idx_q + 2'd1;
                        tx_d    = buf_q[idx_d];
                        state_d = R_SEND;
                    end
                end
            end
            default: state_d = R_IDLE;
        endcase
    end

    assign tx_data_o = tx_q;
    assign active_o  = (state_q != R_IDLE);

endmodule

// File: rtl/uart_led_cmd.sv
// ASCII line parser between UART RX and TX: "Lhh" sets the LEDs, "R" reads them back,
// anything malformed answers "?". Bytes arriving while a reply is in flight are dropped.
module uart_led_cmd
    import uart_led_cmd_pkg::*;
#(
    parameter int LED_WIDTH    = 8,
    parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
    input  logic                 i_Clock,
    input  logic                 i_Reset,
    input  logic                 i_Received,
    input  logic [7:0]           i_RxData,
    input  logic                 i_Busy,
    output logic                 o_Start,
    output logic [7:0]           o_TxData,
    output logic [LED_WIDTH-1:0] o_Leds,
    output logic                 o_Overrun
);

    parse_state_e         parse_q, parse_d;
    logic                 rx_prev_q;
    logic [3:0]           hi_q, hi_d, lo_q, lo_d;
    logic [LED_WIDTH-1:0] leds_q, leds_d;
    logic                 ovr_q, ovr_d;

    logic            byte_acc, is_lf, seq_active, load;
    logic [2:0][7:0] rep_bytes;
    logic [1:0]      rep_len;
    logic [7:0]      byte_val, led_ext;

    assign byte_acc = i_Received && !rx_prev_q;
    assign is_lf    = (i_RxData == ASCII_LF);
    assign byte_val = {hi_q, lo_q};

    always_comb begin
        led_ext = '0;
        led_ext[LED_WIDTH-1:0] = leds_q;
    end

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            parse_q   <= P_IDLE;
            rx_prev_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            leds_q    <= '0;
            ovr_q     <= 1'b0;
        end else begin
            parse_q   <= parse_d;
            rx_prev_q <= i_Received;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            leds_q    <= leds_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        parse_d   = parse_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        leds_d    = leds_q;
        ovr_d     = ovr_q;
        load      = 1'b0;
        rep_bytes = '0;
        rep_len   = 2'd0;
        if (byte_acc) begin
            if (seq_active) begin
                ovr_d = 1'b1;
            end else if (i_RxData != ASCII_CR) begin
                case (parse_q)
                    P_IDLE: begin
                        // OR-ing 0x20 folds upper and lower case letters together.
                        if ((i_RxData | 8'h20) == (ASCII_L | 8'h20))      parse_d = P_GOT_L;
                        else if ((i_RxData | 8'h20) == (ASCII_R | 8'h20)) parse_d = P_GOT_R;
                        else if (!is_lf)                                  parse_d = P_BAD;
                    end
                    P_GOT_L, P_HEX1: begin
                        if (is_hex(i_RxData)) begin
                            if (parse_q == P_GOT_L) begin
                                hi_d    = hex_to_nibble(i_RxData);
                                parse_d = P_HEX1;
                            end else begin
                                lo_d    = hex_to_nibble(i_RxData);
                                parse_d = P_HEX2;
                            end
                        end else if (is_lf) begin
                            load         = 1'b1;
                            rep_bytes[0] = ASCII_QM;
                            rep_bytes[1] = ASCII_LF;
                            rep_len      = 2'd2;
                            parse_d      = P_IDLE;
                        end else begin
                            parse_d = P_BAD;
                        end
                    end
                    P_HEX2: begin
                        if (is_lf) begin
                            leds_d       = byte_val[LED_WIDTH-1:0];
                            load         = 1'b1;
                            rep_bytes[0] = ASCII_K;
                            rep_bytes[1] = ASCII_LF;
                            rep_len      = 2'd2;
                            parse_d      = P_IDLE;
                        end else begin
                            parse_d = P_BAD;
                        end
                    end
                    P_GOT_R: begin
                        if (is_lf) begin
                            load         = 1'b1;
                            rep_bytes[0] = nibble_to_hex(led_ext[7:4]);
                            rep_bytes[1] = nibble_to_hex(led_ext[3:0]);
                            rep_bytes[2] = ASCII_LF;
                            rep_len      = 2'd3;
                            parse_d      = P_IDLE;
                        end else begin
                            parse_d = P_BAD;
                        end
                    end
                    P_BAD: begin
                        if (is_lf) begin
                            load         = 1'b1;
                            rep_bytes[0] = ASCII_QM;
                            rep_bytes[1] = ASCII_LF;
                            rep_len      = 2'd2;
                            parse_d      = P_IDLE;
                        end
                    end
                    default: parse_d = P_IDLE;
                endcase
            end
        end
    end

    uart_tx_sequencer #(
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) u_seq (
        .clk_i     (i_Clock),
        .rst_i     (i_Reset),
        .load_i    (load),
        .bytes_i   (rep_bytes),
        .len_i     (rep_len),
        .busy_i    (i_Busy),
        .start_o   (o_Start),
        .tx_data_o (o_TxData),
        .active_o  (seq_active)
    );

    assign o_Leds    = leds_q;
    assign o_Overrun = ovr_q;

endmodule
